// File: rtl/instr_encoder_pkg.sv
// Shared MIPS definitions for the program loader: opcode enum, loader
// FSM state enum and instruction field widths.
package instr_encoder_pkg;

  localparam int OP_W  = 6;
  localparam int REG_W = 5;
  localparam int IMM_W = 16;
  localparam int TGT_W = 26;

  // Enum value is the literal 6-bit opcode field of the instruction word.
  typedef enum logic [OP_W-1:0] {
    RTYP  = 6'h00,
    J     = 6'h02,
    BEQZ  = 6'h04,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0A,
    SUBI  = 6'h0B,
    ANDI  = 6'h0C,
    ORI   = 6'h0D,
    XORI  = 6'h0E,
    LUI   = 6'h0F,
    LW    = 6'h23,
    SW    = 6'h2B
  } op_t;

  typedef enum logic [1:0] {
    ENC_IDLE   = 2'd0,
    ENC_ACCEPT = 2'd1,
    ENC_WRITE  = 2'd2,
    ENC_DONE   = 2'd3
  } enc_state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational golden encoder, symbolic fields -> 32-bit
// MIPS R/I/J word. Unknown opcodes produce a zero word and raise illegal.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  op_t              op,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic [OP_W-1:0]  funct,
  input  logic [IMM_W-1:0] imm,
  input  logic [TGT_W-1:0] target,
  output logic [31:0]      word,
  output logic             illegal
);

  // Select the field layout from the opcode class.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      RTYP:    word = {op, rs, rt, rd, 5'b0, funct};
      J:       word = {op, target};
      LUI:     word = {op, {REG_W{1'b0}}, rt, imm};
      BEQZ, ADDI, ADDIU, SUBI, SLTI, ANDI, ORI, XORI, LW, SW:
               word = {op, rs, rt, imm};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: program loader in front of imem. Accepts symbolic
// instruction fields over valid/ready, packs them and writes one word at a
// time to an auto-incrementing address. Optional running XOR checksum of
// written words is enabled by defining ENC_CHECKSUM_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_t               in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [1:0] IDLE   = ENC_IDLE;
  localparam logic [1:0] ACCEPT = ENC_ACCEPT;
  localparam logic [1:0] WRITE  = ENC_WRITE;
  localparam logic [1:0] DONE   = ENC_DONE;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [1:0]        state_reg;
  logic              err_reg;
  logic              last_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic [ADDR_W:0]   count_reg;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic              restart;

  instr_pack u_pack (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // start only counts from IDLE or DONE; mid-load pulses are ignored.
  assign restart = start && ((state_reg == IDLE) || (state_reg == DONE));

  // Loader FSM plus address, count and captured-word registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
      last_reg  <= 1'b0;
      addr_reg  <= BASE;
      wdata_reg <= '0;
      count_reg <= '0;
    end else if (restart) begin
      state_reg <= ACCEPT;
      err_reg   <= 1'b0;
      addr_reg  <= BASE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        ACCEPT: begin
          if (in_valid) begin
            if (pack_illegal) begin
              err_reg <= 1'b1;
              if (in_last) state_reg <= DONE;
            end else begin
              wdata_reg <= pack_word;
              last_reg  <= in_last;
              state_reg <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            count_reg <= count_reg + (ADDR_W + 1)'(1);
            // The top word is the end of imem: stop there instead of wrapping.
            if (addr_reg == LAST_ADDR) begin
              if (!last_reg) err_reg <= 1'b1;
              state_reg <= DONE;
            end else begin
              addr_reg  <= addr_reg + ADDR_W'(1);
              state_reg <= last_reg ? DONE : ACCEPT;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] checksum_reg;

  // Fold every acknowledged word into the running checksum.
  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      checksum_reg <= '0;
    end else if ((state_reg == WRITE) && mem_ack) begin
      checksum_reg <= checksum_reg ^ wdata_reg;
    end
  end

  assign checksum = checksum_reg;
`endif

  assign in_ready  = (state_reg == ACCEPT);
  assign busy      = (state_reg == ACCEPT) || (state_reg == WRITE);
  assign done      = (state_reg == DONE);
  assign mem_req   = (state_reg == WRITE);
  assign err       = err_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign count     = count_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2 so overflow is reachable).
// Build with ENC_CHECKSUM_EN defined to also check the checksum port.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic mem_ack = 1'b0;
  op_t  in_op = RTYP;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;

  logic          in_ready, mem_req, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_addr, m_count;
  bit          m_err, m_done;
  logic [31:0] m_ck;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .count(count), .busy(busy), .done(done), .err(err)
`ifdef ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // Field placement by arithmetic: opcode at bit 26, rs 21, rt 16, rd 11.
  function automatic bit ref_encode(input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] funct,
      input logic [15:0] imm, input logic [25:0] tgt, output logic [31:0] w);
    logic [31:0] opf;
    opf = 32'(op) << 26;
    w = 32'h0;
    if (op == 6'h00) w = opf | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(funct);
    else if (op == 6'(J)) w = opf | 32'(tgt);
    else if (op == 6'(LUI)) w = opf | (32'(rt) << 16) | 32'(imm);
    else if (op inside {BEQZ, ADDI, ADDIU, SUBI, SLTI, ANDI, ORI, XORI, LW, SW})
      w = opf | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
    else return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    m_addr = 0; m_count = 0; m_err = 0; m_done = 0; m_ck = '0;
    vectors++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || count !== '0 || err !== 1'b0 || done !== 1'b0 || mem_addr !== '0) begin
      miscompares++;
      $display("FAIL start: ready=%b busy=%b count=%0d err=%b done=%b addr=%0d required 1 1 0 0 0 0",
               in_ready, busy, count, err, done, mem_addr);
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
      input logic [25:0] tgt, input bit last, input int stall);
    logic [31:0] w;
    bit legal;
    int n;
    legal = ref_encode(op, rs, rt, rd, funct, imm, tgt, w);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
      return;
    end
    in_op = op_t'(op); in_rs = rs; in_rt = rt; in_rd = rd; in_funct = funct;
    in_imm = imm; in_target = tgt; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    if (legal) begin
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== AW'(m_addr) || mem_wdata !== w || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL write_issue: req=%b addr=%0d data=%h ready=%b required 1 %0d %h 0",
                 mem_req, mem_addr, mem_wdata, in_ready, m_addr, w);
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== AW'(m_addr) || mem_wdata !== w || in_ready !== 1'b0 || count !== (AW+1)'(m_count)) begin
          miscompares++;
          $display("FAIL write_stall: cyc=%0d req=%b addr=%0d data=%h ready=%b count=%0d required 1 %0d %h 0 %0d",
                   s, mem_req, mem_addr, mem_wdata, in_ready, count, m_addr, w, m_count);
        end
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      m_count++;
      m_ck ^= w;
      if (m_addr == (1 << AW) - 1) begin
        m_done = 1;
        if (!last) m_err = 1;
      end else begin
        m_addr++;
        if (last) m_done = 1;
      end
      vectors++;
      if (mem_req !== 1'b0 || count !== (AW+1)'(m_count) || mem_addr !== AW'(m_addr)
          || done !== m_done || err !== m_err || in_ready !== !m_done) begin
        miscompares++;
        $display("FAIL write_done: req=%b count=%0d addr=%0d done=%b err=%b ready=%b required 0 %0d %0d %b %b %b",
                 mem_req, count, mem_addr, done, err, in_ready, m_count, m_addr, m_done, m_err, !m_done);
      end
`ifdef ENC_CHECKSUM_EN
      vectors++;
      if (checksum !== m_ck) begin
        miscompares++;
        $display("FAIL checksum: got %h required %h", checksum, m_ck);
      end
`endif
      $display("write op=%h addr=%0d word=%h stall=%0d", op, m_count - 1, w, stall);
    end else begin
      m_err = 1;
      if (last) m_done = 1;
      vectors++;
      if (mem_req !== 1'b0 || err !== 1'b1 || count !== (AW+1)'(m_count) || done !== m_done) begin
        miscompares++;
        $display("FAIL illegal_op: req=%b err=%b count=%0d done=%b required 0 1 %0d %b",
                 mem_req, err, count, done, m_count, m_done);
      end
      $display("illegal op=%h dropped last=%0b", op, last);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (in_ready !== 0 || mem_req !== 0 || busy !== 0 || done !== 0 || err !== 0
        || mem_addr !== '0 || mem_wdata !== '0 || count !== '0) begin
      miscompares++;
      $display("FAIL reset: ready=%b req=%b busy=%b done=%b err=%b addr=%0d data=%h count=%0d required all 0",
               in_ready, mem_req, busy, done, err, mem_addr, mem_wdata, count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 0 || busy !== 0) begin
      miscompares++;
      $display("FAIL idle_hold: ready=%b busy=%b required 0 0", in_ready, busy);
    end
    $display("reset checked");
  endtask

  task automatic test_rtype();
    do_start();
    send(6'(RTYP), 5'd2, 5'd3, 5'd4, 6'h20, 16'h0, 26'h0, 1'b1, 0);
    vectors++;
    if (done !== 1'b1 || count !== (AW+1)'(1)) begin
      miscompares++;
      $display("FAIL rtype_done: done=%b count=%0d required 1 1", done, count);
    end
  endtask

  task automatic test_two_words();
    do_start();
    send(6'(ADDI), 5'd1, 5'd2, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b0, 1);
    send(6'(J), 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h10, 1'b1, 0);
  endtask

  task automatic test_stall();
    do_start();
    send(6'(ORI), 5'd9, 5'd10, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b1, 5);
  endtask

  task automatic test_lui_illegal();
    do_start();
    send(6'(LUI), 5'd7, 5'd8, 5'd0, 6'h0, 16'hABCD, 26'h0, 1'b0, 0);
    send(6'h3F, 5'd1, 5'd1, 5'd1, 6'h0, 16'h1, 26'h0, 1'b0, 0);
    send(6'(XORI), 5'd3, 5'd4, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b1, 0);
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 4; i++)
      send(6'(ADDIU), 5'(i), 5'(i + 1), 5'd0, 6'h0, 16'(i * 3), 26'h0, 1'b0, 0);
    in_op = SW; in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (count !== (AW+1)'(4) || mem_req !== 0 || in_ready !== 0 || done !== 1 || err !== 1) begin
      miscompares++;
      $display("FAIL overflow: count=%0d req=%b ready=%b done=%b err=%b required 4 0 0 1 1",
               count, mem_req, in_ready, done, err);
    end
    $display("overflow checked");
  endtask

  task automatic test_start_while_busy();
    do_start();
    send(6'(LW), 5'd5, 5'd6, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b0, 0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++;
    if (count !== (AW+1)'(1) || mem_addr !== AW'(1) || in_ready !== 1) begin
      miscompares++;
      $display("FAIL start_busy: count=%0d addr=%0d ready=%b required 1 1 1", count, mem_addr, in_ready);
    end
    send(6'(SW), 5'd5, 5'd6, 5'd0, 6'h0, 16'h0014, 26'h0, 1'b1, 2);
  endtask

  task automatic test_reset_mid_write();
    do_start();
    @(negedge clk);
    in_op = BEQZ; in_rs = 5'd1; in_imm = 16'h7; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midwrite_req: req=%b required 1", mem_req);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    vectors++;
    if (in_ready !== 0 || mem_req !== 0 || busy !== 0 || done !== 0 || err !== 0
        || mem_addr !== '0 || mem_wdata !== '0 || count !== '0) begin
      miscompares++;
      $display("FAIL midwrite_reset: ready=%b req=%b busy=%b done=%b err=%b addr=%0d data=%h count=%0d required all 0",
               in_ready, mem_req, busy, done, err, mem_addr, mem_wdata, count);
    end
`ifdef ENC_CHECKSUM_EN
    vectors++;
    if (checksum !== '0) begin
      miscompares++;
      $display("FAIL midwrite_checksum: got %h required 0", checksum);
    end
`endif
    $display("reset during write checked");
  endtask

  task automatic test_random();
    logic [5:0] ops [15];
    logic [31:0] dummy;
    logic [5:0] op;
    int len, writes;
    bit lg, last;
    ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
            6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F, 6'h11};
    for (int p = 0; p < 20; p++) begin
      do_start();
      len = $urandom_range(1, 6);
      writes = 0;
      for (int i = 0; i < len; i++) begin
        op = ops[$urandom_range(0, 14)];
        lg = ref_encode(op, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, dummy);
        last = (i == len - 1) || (lg && writes == 3);
        send(op, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
             16'($urandom), 26'($urandom), last, $urandom_range(0, 3));
        if (lg) writes++;
        if (last) break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_two_words();
    test_stall();
    test_lui_illegal();
    test_overflow();
    test_start_while_busy();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
